// File: rtl/hmm_obs_source.sv
// hmm_obs_source: draws a hidden-state path and an observation sequence from
// an HMM described by cumulative-probability threshold tables, then streams
// the observations with the same start/obs_valid/obs_in handshake that
// viterbi_top consumes. The true hidden path is exported for comparison
// against the decoder's output.
//
// Randomness comes from a 16-bit Galois LFSR (taps 16'hB400). A draw picks
// the smallest index j whose threshold is >= the current LFSR value; the
// last index is the fallback. The LFSR steps once per state draw and once
// per symbol draw, so two steps per observation.
//
// Every output is registered. Each output therefore reflects the state the
// FSM was in during the previous cycle. This gives the latencies below:
//   - go accepted at edge e: the first obs_valid is high after edge e+3.
//   - One observation takes 3+GAP cycles.
//   - done rises GAP+1 cycles after the last obs_valid.
module hmm_obs_source #(
  parameter int unsigned N    = 8,
  parameter int unsigned I    = 3,
  parameter int unsigned K    = 3,
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int unsigned GAP  = 1,
  localparam int unsigned SN  = $clog2(N),
  localparam int unsigned SI  = $clog2(I),
  localparam int unsigned SK  = $clog2(K)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [SN-1:0]     length,
  input  logic [I*16-1:0]   cumC,
  input  logic [I*I*16-1:0] cumA,
  input  logic [I*K*16-1:0] cumB,
  output logic              start,
  output logic [SK-1:0]     obs_in,
  output logic              obs_valid,
  output logic [N*SI-1:0]   true_path,
  output logic              busy,
  output logic              done
);

  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] TAPS     = 16'hB400;

  // The gap is at least one cycle, so EMIT never runs back to back.
  localparam int unsigned GAP_EFF  = (GAP < 1) ? 1 : GAP;
  localparam int unsigned GW       = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_EFF - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SAMP_S = 3'd1;
  localparam logic [2:0] S_SAMP_O = 3'd2;
  localparam logic [2:0] S_EMIT   = 3'd3;
  localparam logic [2:0] S_GAPW   = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  logic [2:0]      state_q,     state_d;
  logic [15:0]     lfsr_q,      lfsr_d;
  logic [SN-1:0]   len_q,       len_d;
  logic [SN-1:0]   t_q,         t_d;
  logic [SI-1:0]   prev_q,      prev_d;
  logic [SK-1:0]   obs_q,       obs_d;
  logic [GW-1:0]   gap_q,       gap_d;
  logic            start_q,     start_d;
  logic [SK-1:0]   obs_in_q,    obs_in_d;
  logic            obs_valid_q, obs_valid_d;
  logic [N*SI-1:0] path_q,      path_d;
  logic            busy_q,      busy_d;
  logic            done_q,      done_d;

  logic [15:0]     lfsr_step;
  logic [I*16-1:0] s_row;
  logic [K*16-1:0] o_row;
  logic [SI-1:0]   s_pick;
  logic [SK-1:0]   o_pick;
  logic            last_obs;

  // Pick the smallest state index whose threshold covers u.
  // Scanning downward leaves the lowest match as the final result.
  function automatic logic [SI-1:0] pick_state(input logic [I*16-1:0] row,
                                               input logic [15:0]   u);
    logic [SI-1:0] sel;
    sel = SI'(I - 1);
    for (int j = int'(I) - 1; j >= 0; j--) begin
      if (u <= row[16*j +: 16]) sel = SI'(j);
    end
    return sel;
  endfunction

  // Same selection rule, applied to one row of the emission table.
  function automatic logic [SK-1:0] pick_sym(input logic [K*16-1:0] row,
                                             input logic [15:0]   u);
    logic [SK-1:0] sel;
    sel = SK'(K - 1);
    for (int j = int'(K) - 1; j >= 0; j--) begin
      if (u <= row[16*j +: 16]) sel = SK'(j);
    end
    return sel;
  endfunction

  // Galois right-shift step; applied only in the two sampling states.
  always_comb begin
    lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
  end

  // Row selection and table lookups for both draws, using the current LFSR value.
  always_comb begin
    s_row  = (t_q == '0) ? cumC : cumA[int'(prev_q)*int'(I)*16 +: I*16];
    o_row  = cumB[int'(prev_q)*int'(K)*16 +: K*16];
    s_pick = pick_state(s_row, lfsr_q);
    o_pick = pick_sym(o_row, lfsr_q);
    last_obs = ((SN+1)'(t_q) + (SN+1)'(1)) == (SN+1)'(len_q);
  end

  // Sequencer next-state logic.
  always_comb begin
    // NOTE: every _d is given its hold value first, so no path through
    // the case statement leaves a variable unassigned. Without this, the
    // tool would infer a latch.
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    len_d       = len_q;
    t_d         = t_q;
    prev_d      = prev_q;
    obs_d       = obs_q;
    gap_d       = gap_q;
    obs_in_d    = obs_in_q;
    path_d      = path_q;
    busy_d      = busy_q;
    start_d     = 1'b0;
    obs_valid_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          path_d = '0;
          t_d    = '0;
          if (length != '0) begin
            len_d   = length;
            busy_d  = 1'b1;
            state_d = S_SAMP_S;
          end else begin
            state_d = S_FIN;
          end
        end
      end

      S_SAMP_S: begin
        path_d[int'(t_q)*int'(SI) +: SI] = s_pick;
        prev_d  = s_pick;
        lfsr_d  = lfsr_step;
        state_d = S_SAMP_O;
      end

      S_SAMP_O: begin
        obs_d   = o_pick;
        lfsr_d  = lfsr_step;
        state_d = S_EMIT;
      end

      S_EMIT: begin
        obs_valid_d = 1'b1;
        obs_in_d    = obs_q;
        start_d     = (t_q == '0);
        gap_d       = '0;
        state_d     = S_GAPW;
      end

      S_GAPW: begin
        if (gap_q == GAP_LAST) begin
          t_d     = t_q + 1'b1;
          state_d = last_obs ? S_FIN : S_SAMP_S;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers. Reset aborts a sequence at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: true_path is an ordinary flop vector, not a RAM. Because of
      // that it can be cleared asynchronously together with the rest of
      // the state.
      state_q     <= S_IDLE;
      lfsr_q      <= SEED_EFF;
      len_q       <= '0;
      t_q         <= '0;
      prev_q      <= '0;
      obs_q       <= '0;
      gap_q       <= '0;
      start_q     <= 1'b0;
      obs_in_q    <= '0;
      obs_valid_q <= 1'b0;
      path_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make every register see pre-edge values,
      // matching the flops that are built.
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      len_q       <= len_d;
      t_q         <= t_d;
      prev_q      <= prev_d;
      obs_q       <= obs_d;
      gap_q       <= gap_d;
      start_q     <= start_d;
      obs_in_q    <= obs_in_d;
      obs_valid_q <= obs_valid_d;
      path_q      <= path_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign start     = start_q;
  assign obs_in    = obs_in_q;
  assign obs_valid = obs_valid_q;
  assign true_path = path_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
